axis_pkt_sf_fifo: RTL
=====================

Name: axis_pkt_sf_fifo

Overview:
Store-and-forward AXI-Stream packet FIFO on the generator egress path. It sits between the pattern generator/checker master port and the 10G MAC/loopback path. It forwards only complete packets and drops whole packets on overflow, so it never emits a truncated frame. It also exposes packet-in, packet-out and drop counters for the AXI-Lite register block.

Parameters:
C_AXIS_DATA_WIDTH, 64, tdata width; tstrb is C_AXIS_DATA_WIDTH/8
C_AXIS_TUSER_WIDTH, 128, tuser width
C_DEPTH_LOG2, 9, data RAM depth 2^C_DEPTH_LOG2 words
C_MAX_PKTS_LOG2, 4, metadata FIFO depth 2^C_MAX_PKTS_LOG2 packets
C_CNT_WIDTH, 32, statistics counter width

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  reset, asynchronous, active-low
s_axis_tdata  in  C_AXIS_DATA_WIDTH  input data
s_axis_tstrb  in  C_AXIS_DATA_WIDTH/8  input byte strobes
s_axis_tuser  in  C_AXIS_TUSER_WIDTH  packet metadata, sampled on first beat
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  constant 1 (overflow handled by dropping)
s_axis_tlast  in  1  last beat of packet
m_axis_tdata  out  C_AXIS_DATA_WIDTH  output data (registered)
m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  output strobes (registered)
m_axis_tuser  out  C_AXIS_TUSER_WIDTH  packet metadata, held for every beat
m_axis_tvalid  out  1  output valid (registered)
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat (registered)
count_reset  in  1  synchronous clear of statistics counters
pkt_in_count  out  C_CNT_WIDTH  packets committed
pkt_out_count  out  C_CNT_WIDTH  packets fully transmitted (tlast handshake)
drop_count  out  C_CNT_WIDTH  packets dropped
fifo_level  out  C_DEPTH_LOG2+1  committed words in RAM = wr_commit - rd_ptr

Behaviour:
- Reset (async): pointers, counters, meta FIFO, m_axis_tvalid/tlast/tdata/tstrb/tuser all 0, input FSM to IN_IDLE. Any partial packet is discarded.
- Storage: RAM word = {tlast, tstrb, tdata}, LUT RAM with combinational read.
- Pointers: wr_ptr (speculative), wr_commit, rd_ptr, each C_DEPTH_LOG2+1 bits, wrapping modulo 2^(C_DEPTH_LOG2+1).
- Full when wr_ptr - rd_ptr == 2^C_DEPTH_LOG2.
- A beat is accepted whenever s_axis_tvalid=1. Beats with tvalid=0 are stalls; state is held.
- Input FSM, IN_IDLE (first beat):
  - If the RAM is full or the meta FIFO is full: drop_count+1, go to IN_DROP (stay in IN_IDLE if tlast).
  - Otherwise: write the word, wr_ptr+1, capture tuser.
  - If tlast on that beat: commit (wr_commit <= wr_ptr+1, push tuser to meta, pkt_in_count+1), stay in IN_IDLE. Otherwise go to IN_WRITE.
- Input FSM, IN_WRITE:
  - If the RAM is full on a beat: wr_ptr <= wr_commit (rollback), drop_count+1. Go to IN_DROP, or to IN_IDLE if that beat carries tlast.
  - Otherwise: write the beat; on tlast commit as above and go to IN_IDLE.
- Input FSM, IN_DROP: discard beats; on a tlast beat go to IN_IDLE.
- Meta space is reserved at the first beat. Pops only free entries, so the push at tlast always succeeds.
- Output load: the output register loads RAM[rd_ptr] and meta head tuser when (!m_axis_tvalid || m_axis_tready) && rd_ptr != wr_commit. On load rd_ptr+1 and m_axis_tvalid=1.
- Load of a tlast word pops meta.
- If no committed word is available while the register is consumed: m_axis_tvalid <= 0.
- Back-to-back loads give full throughput while m_axis_tready=1.
- Output register contents are held stable while tvalid=1 and tready=0.
- Latency: input tlast handshake at edge E → wr_commit at E → load at E+1 → m_axis_tvalid high in the cycle after E+1.
- Simultaneous events:
  - Meta push and pop in the same cycle are both allowed.
  - A write at full is impossible, since the full check precedes the write.
  - The output register counts as one extra word of buffering; rd_ptr advances at load, not at handshake.
- Counters wrap at 2^C_CNT_WIDTH. pkt_out_count increments on m_axis_tvalid&tready&tlast.
- count_reset=1 clears all three counters and has priority over an increment in the same cycle. It does not affect data flow.

Test Plan:
- Packets through, no backpressure: 16-word packet, tready=1 → identical data/strb/tuser out, tlast on beat 16, first m_axis_tvalid 2 cycles after input tlast; pkt_in=pkt_out=1, drop=0.
- Backpressure: tready=0 for 60 cycles while three 16-word packets are written → nothing is lost. After tready=1, 48 beats come out in order with no tvalid gaps; fifo_level returns to 0.
- Mid-packet overflow: C_DEPTH_LOG2=5, tready=0, three 16-word packets. Packet 1 has one word in the output register, packet 2 is stored, and the RAM fills at word 2 of packet 3, which is rolled back → drop_count=1, fifo_level=31. On release exactly 2 packets (32 beats) come out.
- Meta limit: C_MAX_PKTS_LOG2=2, tready=0, six single-beat packets → 5 accepted (1 in output register, 4 in meta), drop_count=1. On release 5 beats come out, each with tlast=1 and its own tuser.
- Drop then recover: with the RAM full, start a packet, release tready mid-drop → dropped beats are never emitted, and the next packet after tlast is stored and forwarded intact.
- Resets: count_reset pulsed in the same cycle as a drop → all counters read 0. axi_aresetn asserted mid-packet → m_axis_tvalid=0 immediately, fifo_level=0, the next packet is forwarded correctly.

Source files
------------

// File: rtl/axis_pkt_sf_fifo.sv
// axis_pkt_sf_fifo: store-and-forward AXI-Stream packet FIFO.
// Emits only complete packets; drops whole packets on RAM/meta overflow.
//
// Ports:
//   axi_aclk / axi_aresetn : clock, async active-low reset
//   s_axis_*               : ingress stream (tready tied high)
//   m_axis_*               : registered egress stream, tuser per packet
//   count_reset            : sync clear of pkt_in/pkt_out/drop counters
//   fifo_level             : committed words held in the data RAM
module axis_pkt_sf_fifo #(
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH_LOG2       = 9,
  parameter int C_MAX_PKTS_LOG2    = 4,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  input  logic                            count_reset,
  output logic [C_CNT_WIDTH-1:0]          pkt_in_count,
  output logic [C_CNT_WIDTH-1:0]          pkt_out_count,
  output logic [C_CNT_WIDTH-1:0]          drop_count,
  output logic [C_DEPTH_LOG2:0]           fifo_level
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH/8;
  localparam int TW = C_AXIS_TUSER_WIDTH;
  localparam int DL = C_DEPTH_LOG2;
  localparam int ML = C_MAX_PKTS_LOG2;
  localparam int PW = DL+1;
  localparam int MW = ML+1;
  localparam int RW = 1+SW+DW;

  localparam logic [PW-1:0] P1 = PW'(1);
  localparam logic [MW-1:0] M1 = MW'(1);
  localparam logic [C_CNT_WIDTH-1:0] C1 = C_CNT_WIDTH'(1);
  localparam logic [PW-1:0] DEPTH = {1'b1, {DL{1'b0}}};
  localparam logic [MW-1:0] MDEPTH = {1'b1, {ML{1'b0}}};

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_WRITE,
    IN_DROP
  } in_st_e;

  logic [RW-1:0] ram [2**DL];
  logic [TW-1:0] meta [2**ML];

  in_st_e        st_q, st_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_q, commit_d;
  logic [PW-1:0] rd_ptr_q;
  logic [TW-1:0] tuser_q, tuser_d;
  logic [MW-1:0] meta_wr_q, meta_rd_q;

  logic [DW-1:0] m_tdata_q;
  logic [SW-1:0] m_tstrb_q;
  logic [TW-1:0] m_tuser_q;
  logic          m_tvalid_q, m_tlast_q;

  logic [C_CNT_WIDTH-1:0] in_cnt_q, out_cnt_q, drop_cnt_q;

  logic          ram_we, meta_push, in_inc, drop_inc;
  logic [TW-1:0] push_user;
  logic [PW-1:0] used;
  logic [MW-1:0] meta_used;
  logic          full, meta_full;
  logic          load, pop, out_inc;
  logic [RW-1:0] rd_word;

  // used counts speculative words too, so a packet in flight
  // can never overwrite a committed word
  assign used      = wr_ptr_q - rd_ptr_q;
  assign full      = (used == DEPTH);
  assign meta_used = meta_wr_q - meta_rd_q;
  assign meta_full = (meta_used == MDEPTH);

  assign rd_word = ram[rd_ptr_q[DL-1:0]];
  assign load    = (!m_tvalid_q || m_axis_tready) &&
                   (rd_ptr_q != commit_q);
  assign pop     = load && rd_word[RW-1];
  assign out_inc = m_tvalid_q && m_axis_tready && m_tlast_q;

  always_comb begin
    st_d      = st_q;
    wr_ptr_d  = wr_ptr_q;
    commit_d  = commit_q;
    tuser_d   = tuser_q;
    ram_we    = 1'b0;
    meta_push = 1'b0;
    push_user = tuser_q;
    in_inc    = 1'b0;
    drop_inc  = 1'b0;
    if (s_axis_tvalid) begin
      unique case (st_q)
        IN_IDLE: begin
          // meta slot is checked here so the push at tlast
          // always finds room
          if (full || meta_full) begin
            drop_inc = 1'b1;
            if (!s_axis_tlast) st_d = IN_DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + P1;
            tuser_d  = s_axis_tuser;
            if (s_axis_tlast) begin
              commit_d  = wr_ptr_q + P1;
              meta_push = 1'b1;
              push_user = s_axis_tuser;
              in_inc    = 1'b1;
            end else begin
              st_d = IN_WRITE;
            end
          end
        end
        IN_WRITE: begin
          if (full) begin
            wr_ptr_d = commit_q;
            drop_inc = 1'b1;
            st_d     = s_axis_tlast ? IN_IDLE : IN_DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + P1;
            if (s_axis_tlast) begin
              commit_d  = wr_ptr_q + P1;
              meta_push = 1'b1;
              in_inc    = 1'b1;
              st_d      = IN_IDLE;
            end
          end
        end
        IN_DROP: begin
          if (s_axis_tlast) st_d = IN_IDLE;
        end
        default: st_d = IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (ram_we) begin
      ram[wr_ptr_q[DL-1:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    end
    if (meta_push) begin
      meta[meta_wr_q[ML-1:0]] <= push_user;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      st_q      <= IN_IDLE;
      wr_ptr_q  <= '0;
      commit_q  <= '0;
      tuser_q   <= '0;
      meta_wr_q <= '0;
      meta_rd_q <= '0;
    end else begin
      st_q     <= st_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      tuser_q  <= tuser_d;
      if (meta_push) meta_wr_q <= meta_wr_q + M1;
      if (pop)       meta_rd_q <= meta_rd_q + M1;
    end
  end

  // rd_ptr moves at load: the output register is one extra word
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rd_ptr_q   <= '0;
      m_tdata_q  <= '0;
      m_tstrb_q  <= '0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else if (load) begin
      rd_ptr_q   <= rd_ptr_q + P1;
      m_tdata_q  <= rd_word[DW-1:0];
      m_tstrb_q  <= rd_word[RW-2:DW];
      m_tlast_q  <= rd_word[RW-1];
      m_tuser_q  <= meta[meta_rd_q[ML-1:0]];
      m_tvalid_q <= 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (count_reset) begin
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (in_inc)   in_cnt_q   <= in_cnt_q + C1;
      if (out_inc)  out_cnt_q  <= out_cnt_q + C1;
      if (drop_inc) drop_cnt_q <= drop_cnt_q + C1;
    end
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tstrb  = m_tstrb_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign pkt_in_count  = in_cnt_q;
  assign pkt_out_count = out_cnt_q;
  assign drop_count    = drop_cnt_q;
  assign fifo_level    = commit_q - rd_ptr_q;

endmodule
